// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and parity helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  // Even parity is the XOR of the data; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake into the UART transmitter holding register.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Ready;

  modport master (output i_TX_DV, output i_TX_Byte, input o_TX_Ready);
  modport slave  (input i_TX_DV, input i_TX_Byte, output o_TX_Ready);

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an LSB-first serializer
// with optional parity and 1 or 2 stop bits, timed by the shared sample_tick.
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the holding register
// START  | start bit (line 0)
// DATA   | data bits 0..7, LSB first
// PARITY | parity bit (only when PARITY_EN)
// STOP   | stop bit(s), line high, STOP_BITS bit times
// DONE   | one clock between frames, raises o_TX_Done
module uart_tx
  import uart_pkg::*;
#(
  parameter int TICK_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      i_Clock,
  input  logic      i_reset,
  input  logic      sample_tick,
  uart_tx_if.slave  bus,
  output logic      o_TX_Serial,
  output logic      o_TX_Active,
  output logic      o_TX_Done
);

  localparam int               CNT_W     = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_PER_BIT - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] hold_byte;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 hold_full;
  logic                 par_bit;
  logic                 in_bit;
  logic                 bit_end;
  logic                 load;
  logic                 line_d;
  logic                 active_d;
  logic                 done_d;

  assign bus.o_TX_Ready = ~hold_full;
  assign load    = (state == ST_IDLE) && hold_full;
  assign in_bit  = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);
  assign bit_end = in_bit && sample_tick && (tick_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: bit states advance only on the terminal tick of a bit time.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hold_full) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA:   if (bit_end && (bit_idx == LAST_DATA))
                   state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end && (stop_idx == STOP_LAST)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: line level and flags implied by the current state.
  always_comb begin
    line_d   = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state)
      ST_START:  begin line_d = 1'b0;               active_d = 1'b1; end
      ST_DATA:   begin line_d = shift_reg[bit_idx]; active_d = 1'b1; end
      ST_PARITY: begin line_d = par_bit;            active_d = 1'b1; end
      ST_STOP:   active_d = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default:   ;
    endcase
  end

  // Holding register: unload into the shifter takes priority; a write can
  // only land while empty, so the two never collide.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (bus.i_TX_DV && !hold_full) begin
      hold_full <= 1'b1;
      hold_byte <= bus.i_TX_Byte;
    end
  end

  // Shifter, parity latch and bit timing counters.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
    end else if (load) begin
      shift_reg <= hold_byte;
      par_bit   <= parity_bit(hold_byte, PARITY_ODD);
      tick_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
    end else begin
      if (in_bit && sample_tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      if ((state == ST_DATA) && bit_end)
        bit_idx <= (bit_idx == LAST_DATA) ? 3'd0 : bit_idx + 3'd1;
      if ((state == ST_STOP) && bit_end)
        stop_idx <= (stop_idx == STOP_LAST) ? 1'b0 : 1'b1;
    end
  end

  // Registered pad outputs; reset forces the line high immediately.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Serial <= line_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) driven from one
// stimulus stream and compared every cycle against a frame-level model.
module tb_uart_tx;

  localparam int TPB = 16;
  localparam int CFG_STOP [3] = '{1, 2, 1};
  localparam int CFG_PAR  [3] = '{0, 1, 1};
  localparam int CFG_ODD  [3] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       tick = 1'b0;
  logic       tb_dv;
  logic [7:0] tb_byte;
  logic       tick_en;
  logic       chk_on;
  logic [2:0] ser, act, dne, rdy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_if bus ();
    assign bus.i_TX_DV   = tb_dv;
    assign bus.i_TX_Byte = tb_byte;
    assign rdy[g]        = bus.o_TX_Ready;

    uart_tx #(
      .TICK_PER_BIT(TPB),
      .STOP_BITS   (CFG_STOP[g]),
      .PARITY_EN   (CFG_PAR[g] != 0),
      .PARITY_ODD  (CFG_ODD[g] != 0)
    ) dut (
      .i_Clock    (clk),
      .i_reset    (rst_b),
      .sample_tick(tick),
      .bus        (bus.slave),
      .o_TX_Serial(ser[g]),
      .o_TX_Active(act[g]),
      .o_TX_Done  (dne[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of bit values; position is ticks since the load.
  function automatic int nbits(input int k);
    return 1 + 8 + CFG_PAR[k] + CFG_STOP[k];
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] b, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && CFG_PAR[k] != 0) begin
      ones = 0;
      for (int j = 0; j < 8; j++) ones += int'(b[j]);
      if (CFG_ODD[k] != 0) return (ones % 2) == 0;
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  int         m_phase [3];  // 0 idle, 1 frame on line, 2 done clock
  int         m_pos   [3];
  int         acc_cnt [3];
  logic [7:0] m_byte  [3];
  logic [7:0] hold_b  [3];
  logic       hold_v  [3];
  logic       e_line  [3];
  logic       e_act   [3];
  logic       e_done  [3];
  logic       e_ready [3];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 3; k++) begin
        m_phase[k] = 0; m_pos[k] = 0; hold_v[k] = 1'b0;
        e_line[k] = 1'b1; e_act[k] = 1'b0; e_done[k] = 1'b0; e_ready[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic acc;
        e_line[k] = (m_phase[k] == 1) ? exp_bit(k, m_byte[k], m_pos[k] / TPB) : 1'b1;
        e_act[k]  = (m_phase[k] == 1);
        e_done[k] = (m_phase[k] == 2);
        acc = tb_dv && !hold_v[k];
        case (m_phase[k])
          0: if (hold_v[k]) begin
               m_byte[k] = hold_b[k]; hold_v[k] = 1'b0; m_pos[k] = 0; m_phase[k] = 1;
             end
          1: if (tick) begin
               m_pos[k]++;
               if (m_pos[k] == nbits(k) * TPB) m_phase[k] = 2;
             end
          default: m_phase[k] = 0;
        endcase
        if (acc) begin
          hold_v[k] = 1'b1; hold_b[k] = tb_byte; acc_cnt[k]++;
        end
        e_ready[k] = !hold_v[k];
      end
    end
  end

  // Every-cycle compare of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("serial%0d", k), ser[k], e_line[k]);
        chk($sformatf("active%0d", k), act[k], e_act[k]);
        chk($sformatf("done%0d", k),   dne[k], e_done[k]);
        chk($sformatf("ready%0d", k),  rdy[k], e_ready[k]);
      end
    end
  end

  // Event counters used by the directed literal checks.
  int done_cnt [3];
  int hi_cnt   [3];
  int act_cnt  [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dne[k] === 1'b1) done_cnt[k]++;
      if (act[k] === 1'b1 && ser[k] === 1'b1) hi_cnt[k]++;
      if (act[k] === 1'b1) act_cnt[k]++;
    end
  end

  // Baud enable: one pulse every 4 clocks while enabled.
  initial begin
    int tdiv = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      tick = tick_en && (tdiv == 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); tb_dv = 1'b1; tb_byte = b;
    @(negedge clk); tb_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bit  idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk); n++;
      idle = 1'b1;
      for (int k = 0; k < 3; k++)
        if (m_phase[k] != 0 || hold_v[k]) idle = 1'b0;
    end
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin
    int n, r, hi, b_done [3], b_hi [3], b_act0, b_acc;
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0; hi_cnt[k] = 0; act_cnt[k] = 0; acc_cnt[k] = 0;
    end
    tb_dv = 1'b0; tb_byte = 8'h00; tick_en = 1'b1; chk_on = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_serial", ser[0], 1'b1);
    chk("rst_ready",  rdy[0], 1'b1);
    chk("rst_active", act[0], 1'b0);
    chk("rst_done",   dne[0], 1'b0);
    rst_b = 1'b1;

    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ser[0] === 1'b1 && act[0] === 1'b0) hi++;
    end
    chk("idle_1000_high", hi, 1000);

    // 0x55 8N1 (and the other configs alongside)
    for (int k = 0; k < 3; k++) begin b_done[k] = done_cnt[k]; b_hi[k] = hi_cnt[k]; end
    send_byte(8'h55);
    n = 0;
    while (ser[0] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("b55_start_seen", 32'(n < 200), 32'd1);
    while (ser[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    r = 0;
    while (ser[0] === 1'b1 && r < 200) begin @(negedge clk); r++; end
    chk("b55_bit0_clocks", r, 64);
    wait_idle(3000);
    chk("b55_done_pulses", done_cnt[0] - b_done[0], 1);
    chk("b55_hi_8n1", hi_cnt[0] - b_hi[0], 320);
    chk("b55_hi_8e2", hi_cnt[1] - b_hi[1], 384);
    chk("b55_hi_8o1", hi_cnt[2] - b_hi[2], 384);

    // 0xA3 then 0x0F with DV held high
    b_done[0] = done_cnt[0]; b_hi[0] = hi_cnt[0]; b_acc = acc_cnt[0];
    @(negedge clk); tb_dv = 1'b1; tb_byte = 8'hA3;
    @(negedge clk); tb_byte = 8'h0F;
    n = 0;
    while (acc_cnt[0] < b_acc + 2 && n < 2000) begin @(negedge clk); n++; end
    tb_dv = 1'b0;
    chk("a3_0f_accept_delay", n, 2);
    wait_idle(4000);
    chk("a3_0f_done_pulses", done_cnt[0] - b_done[0], 2);
    chk("a3_0f_hi_8n1", hi_cnt[0] - b_hi[0], 640);

    // 0x07: parity even=1, odd=0; 8E2 holds stop for two bit times
    for (int k = 0; k < 3; k++) b_hi[k] = hi_cnt[k];
    send_byte(8'h07);
    wait_idle(3000);
    chk("b07_hi_8n1", hi_cnt[0] - b_hi[0], 256);
    chk("b07_hi_8e2", hi_cnt[1] - b_hi[1], 384);
    chk("b07_hi_8o1", hi_cnt[2] - b_hi[2], 256);

    // baud stall in data bit 3 of 0xC5 (a 0 bit)
    send_byte(8'hC5);
    n = 0;
    while (!(m_phase[0] == 1 && m_pos[0] / TPB == 4 && m_pos[0] % TPB >= 5) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("stall_reached", 32'(n < 2000), 32'd1);
    tick_en = 1'b0;
    repeat (100) @(negedge clk);
    chk("stall_line_held", ser[0], 1'b0);
    tick_en = 1'b1;
    wait_idle(3000);

    // random traffic with occasional dropped ticks
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tb_dv   = ($urandom_range(0, 15) == 0);
      tb_byte = 8'($urandom);
      tick_en = ($urandom_range(0, 15) != 0);
    end
    tb_dv = 1'b0; tick_en = 1'b1;
    wait_idle(8000);

    // reset during data bit 4 of 0xFF with 0x3C queued
    send_byte(8'hFF);
    n = 0;
    while (!(m_phase[0] == 1 && !hold_v[0]) && n < 100) begin @(negedge clk); n++; end
    send_byte(8'h3C);
    chk("queued_byte_held", 32'(hold_v[0]), 32'd1);
    n = 0;
    while (!(m_phase[0] == 1 && m_pos[0] / TPB == 5 && m_pos[0] % TPB >= 3) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("rst_point_reached", 32'(n < 2000), 32'd1);
    chk("pre_rst_active", act[0], 1'b1);
    @(posedge clk); #1 rst_b = 1'b0; #1;
    chk("midrst_serial", ser[0], 1'b1);
    chk("midrst_active", act[0], 1'b0);
    chk("midrst_ready",  rdy[0], 1'b1);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    b_done[0] = done_cnt[0]; b_act0 = act_cnt[0];
    repeat (400) @(negedge clk);
    chk("post_rst_no_done",  done_cnt[0] - b_done[0], 0);
    chk("post_rst_no_frame", act_cnt[0] - b_act0, 0);
    chk("post_rst_ready",    rdy[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, companion to the team's oversampling UART receiver; shares the same sample_tick baud-rate enable and TICK_PER_BIT bit timing.
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so the next byte can queue while the current one shifts.
- Serializes LSB-first frames: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Sits between the host-side byte source and the TX pad.

Parameters:
TICK_PER_BIT, 16, sample_tick pulses per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.
PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
PARITY_ODD, 0, with PARITY_EN=1: 0 means even parity, 1 means odd parity.

Ports:
i_Clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
sample_tick  in  1  one-clock baud enable, same source as the receiver
i_TX_DV  in  1  byte valid
i_TX_Byte  in  8  byte to send
o_TX_Ready  out  1  holding register empty; byte accepted when i_TX_DV & o_TX_Ready
o_TX_Serial  out  1  serial line, registered, idles high
o_TX_Active  out  1  high while a frame is on the line (START through STOP)
o_TX_Done  out  1  one-clock pulse after the last stop bit completes

Behaviour:
- Interface: reset i_reset, asynchronous, active-low; clock i_Clock.
- Reset values: o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0. Holding register empty, tick counter 0, bit index 0, state IDLE.
- Holding register:
  - Write on i_TX_DV & o_TX_Ready; o_TX_Ready drops the next clock.
  - i_TX_DV while o_TX_Ready=0 is ignored; the byte is not captured.
  - A write in the same clock as the holding register is unloaded into the shifter is not possible, because o_TX_Ready is 0 during that clock.
  - o_TX_Ready returns to 1 the clock after unload.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Line high.
  - If the holding register is full: copy it to the shift register, compute parity (XOR of the byte, inverted if PARITY_ODD), free the holding register, counter=0, go to START.
  - Serial drop occurs 1 clock after entering START (registered output).
- Bit timing, common to all bit states:
  - The counter increments only on sample_tick.
  - On the sample_tick where the counter equals TICK_PER_BIT-1, the counter clears and the state or bit advances.
  - Each bit lasts exactly TICK_PER_BIT ticks, counted from the first tick in that state.
  - The start bit additionally includes the partial tick phase between load and the first tick.
  - With no sample_tick, all timing freezes; the line holds its value.
- START: line 0; after TICK_PER_BIT ticks go to DATA with bit_index=0.
- DATA:
  - Line = shift[bit_index].
  - At end of bit, bit_index increments.
  - After bit 7, bit_index clears and the next state is PARITY if PARITY_EN, else STOP.
- PARITY: line = parity bit; after one bit time go to STOP.
- STOP:
  - Line 1.
  - Lasts STOP_BITS*TICK_PER_BIT ticks; use a stop sub-counter, not a separate state.
  - Then go to DONE.
- DONE:
  - One clock; o_TX_Done=1; line 1; o_TX_Active=0 in this clock; then IDLE.
  - A queued byte therefore starts 2 clocks after DONE, so the minimum inter-frame idle is the stop period plus 2 clocks.
- o_TX_Active = 1 in START/DATA/PARITY/STOP, registered alongside o_TX_Serial.
- Counter width is $clog2(TICK_PER_BIT). Bit index is 3 bits and never wraps beyond 7.
- Reset mid-frame:
  - Line returns to 1 immediately (async).
  - Holding register is cleared; any queued byte is lost.
  - The frame is aborted and is not resumed after reset release.
- Illegal state encoding: go to IDLE with line 1.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE..DONE, 3 bits), shared naming with the receiver;
  - DATA_BITS=8;
  - a parity helper function.
- The receiver's tick generator is reused by instantiation at top level, not inside this block.
- No sub-module needed: holding register, shifter and FSM together stay under 250 lines.

Test Plan:
All cases use TICK_PER_BIT=16 and sample_tick every 4 clocks unless stated.
- Reset → o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0. Release with no DV → line stays 1 for 1000 clocks.
- Send 0x55, 8N1 → line sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks (64 clocks). One o_TX_Done pulse. The team's UART receiver in loopback outputs 0x55 with o_RX_DV.
- Send 0xA3 then 0x0F with DV held high → 0x0F is accepted only when o_TX_Ready returns after the 0xA3 load. Both frames appear in order, with a 16-tick stop bit between them. Exactly 2 o_TX_Done pulses.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 → parity bit 1. With PARITY_ODD=1 → parity bit 0. STOP_BITS=2 → stop high for 32 ticks.
- Stall sample_tick for 100 clocks mid-DATA → line holds its current bit, and the remaining bit time resumes unchanged.
- Assert reset mid bit 4 of 0xFF with a byte queued → line 1 within the same cycle. After release: idle, o_TX_Ready=1, no o_TX_Done, and the queued byte is not sent.
